// File: rtl/mmio_bus_initiator.sv
// FPro MMIO bus master: runs one write, read or masked poll per command and
// returns one response per command over valid/ready handshakes.
module mmio_bus_initiator #(
  parameter int LIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [20:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [31:0]      cmd_mask,
  input  logic [LIM_W-1:0] cmd_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             mmio_cs,
  output logic             mmio_wr,
  output logic             mmio_rd,
  output logic [20:0]      mmio_addr,
  output logic [31:0]      mmio_wr_data,
  input  logic [31:0]      mmio_rd_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_POLL = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [31:0]      mask_q;
  logic [LIM_W-1:0] lim_q;
  logic [LIM_W-1:0] cnt_q;
  logic [LIM_W-1:0] cnt_nxt;
  logic [LIM_W-1:0] lim_eff;
  logic             hit;

  // mmio_wr_data doubles as the poll match value once a poll is latched
  always_comb begin
    cnt_nxt = cnt_q + 1'b1;
    lim_eff = lim_q;
    if (lim_q == '0)
      lim_eff = LIM_W'(1);
    hit = ((mmio_rd_data ^ mmio_wr_data) & mask_q) == 32'd0;
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE) && !reset;
    rsp_valid = (state == ST_RESP) && !reset;
    busy      = (state != ST_IDLE);
    mmio_cs   = (state == ST_BUS) && !reset;
    mmio_wr   = mmio_cs && (op_q == OP_WR);
    mmio_rd   = mmio_cs && (op_q != OP_WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= OP_WR;
      rsp_data     <= 32'd0;
      rsp_err      <= 1'b0;
      mmio_addr    <= 21'd0;
      mmio_wr_data <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q         <= cmd_op;
            mmio_addr    <= cmd_addr;
            mmio_wr_data <= cmd_wdata;
            if (cmd_op == OP_RSV) begin
              state    <= ST_RESP;
              rsp_data <= 32'd0;
              rsp_err  <= 1'b1;
            end else begin
              state <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          case (op_q)
            OP_WR: begin
              state    <= ST_RESP;
              rsp_data <= 32'd0;
              rsp_err  <= 1'b0;
            end
            OP_RD: begin
              state    <= ST_RESP;
              rsp_data <= mmio_rd_data;
              rsp_err  <= 1'b0;
            end
            OP_POLL: begin
              if (hit) begin
                state    <= ST_RESP;
                rsp_data <= mmio_rd_data;
                rsp_err  <= 1'b0;
              end else if (cnt_nxt == lim_eff) begin
                state    <= ST_RESP;
                rsp_data <= mmio_rd_data;
                rsp_err  <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end
            default: begin
              state    <= ST_RESP;
              rsp_data <= 32'd0;
              rsp_err  <= 1'b1;
            end
          endcase
        end
        ST_GAP:  state <= ST_BUS;
        default: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
      endcase
    end
  end

  // Poll bookkeeping: the limit compare ends a poll before the counter can wrap
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && cmd_valid) begin
      mask_q <= cmd_mask;
      lim_q  <= cmd_limit;
      cnt_q  <= '0;
    end else if (state == ST_BUS) begin
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Bench for mmio_bus_initiator: directed table, reset corner cases and
// randomized transactions checked against a transaction-level model.
module tb_mmio_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic [15:0] cmd_limit;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

  logic [7:0][31:0] cur_seq;
  logic [2:0]       rd_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Slot read data is only meaningful during a bus cycle; poison it otherwise
  assign mmio_rd_data = mmio_cs ? cur_seq[rd_idx] : 32'hDEADBEEF;

  mmio_bus_initiator #(.LIM_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .cmd_limit(cmd_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data)
  );

  typedef struct packed {
    logic [1:0]       op;
    logic [20:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      mask;
    logic [15:0]      limit;
    logic [7:0][31:0] seq;
    logic [31:0]      exp_data;
    logic             exp_err;
    int               exp_rd;
    int               exp_wr;
  } vec_t;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0][31:0] mk_seq(input logic [31:0] a, b, c, d);
    logic [7:0][31:0] s;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int i = 4; i < 8; i++) s[i] = d;
    return s;
  endfunction

  function automatic vec_t mk_vec(input logic [1:0] op, input logic [20:0] addr,
                                  input logic [31:0] wdata, mask,
                                  input logic [15:0] limit,
                                  input logic [7:0][31:0] seq,
                                  input logic [31:0] ed, input logic ee,
                                  input int erd, input int ewr);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.mask = mask; v.limit = limit;
    v.seq = seq; v.exp_data = ed; v.exp_err = ee; v.exp_rd = erd; v.exp_wr = ewr;
    return v;
  endfunction

  // Transaction-level outcome: result, access counts, response cycle, bus-cycle set
  function automatic void model(input vec_t v, output logic [31:0] d,
                                output logic e, output int nrd, output int nwr,
                                output int rcyc, output int bmask);
    int lim;
    bit matched;
    d = 32'd0; e = 1'b0; nrd = 0; nwr = 0; bmask = 0; rcyc = 0;
    case (v.op)
      2'd0: begin nwr = 1; rcyc = 2; bmask = 1 << 1; end
      2'd1: begin nrd = 1; rcyc = 2; bmask = 1 << 1; d = v.seq[0]; end
      2'd2: begin
        lim = (v.limit == 16'd0) ? 1 : int'(v.limit);
        matched = 1'b0;
        for (int i = 0; i < lim && !matched; i++) begin
          nrd = i + 1;
          bmask |= 1 << (2 * i + 1);
          if ((v.seq[i] & v.mask) == (v.wdata & v.mask)) matched = 1'b1;
        end
        d = v.seq[nrd - 1];
        e = !matched;
        rcyc = 2 * nrd;
      end
      default: begin e = 1'b1; rcyc = 1; end
    endcase
  endfunction

  task automatic run_txn(input vec_t v, input int hold, input string tag);
    logic [31:0] md, d;
    logic        me, e, rd_hit;
    int          mrd, mwr, mrc, mbm;
    int          nrd, nwr, bm, rc;
    model(v, md, me, mrd, mwr, mrc, mbm);
    nrd = 0; nwr = 0; bm = 0; rc = -1; d = 32'd0; e = 1'b0;
    @(negedge clk);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_mask = v.mask; cmd_limit = v.limit;
    cur_seq = v.seq; rd_idx = 3'd0;
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && rc < 0; cyc++) begin
      @(negedge clk);
      rd_hit = 1'b0;
      if (mmio_cs) begin
        if (cyc < 32) bm |= 1 << cyc;
        chk({tag, " bus_addr"}, 64'(mmio_addr), 64'(v.addr));
        if (mmio_rd) begin nrd++; rd_hit = 1'b1; end
        if (mmio_wr) begin
          nwr++;
          chk({tag, " bus_wr_data"}, 64'(mmio_wr_data), 64'(v.wdata));
        end
      end
      if (rsp_valid) begin
        rc = cyc; d = rsp_data; e = rsp_err;
      end else begin
        @(posedge clk);
        #1;
        if (rd_hit) rd_idx++;
      end
    end
    if (rc < 0) begin
      chk({tag, " rsp_timeout"}, 64'd0, 64'd1);
      rsp_ready = 1'b1;
    end else begin
      repeat (hold) begin
        @(negedge clk);
        chk({tag, " hold_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, " hold_data"}, 64'(rsp_data), 64'(d));
        chk({tag, " hold_err"}, 64'(rsp_err), 64'(e));
        chk({tag, " hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, " hold_cs"}, 64'(mmio_cs), 64'd0);
      end
      rsp_ready = 1'b1;
    end
    chk({tag, " rsp_data"}, 64'(d), 64'(v.exp_data));
    chk({tag, " rsp_err"}, 64'(e), 64'(v.exp_err));
    chk({tag, " n_reads"}, 64'(nrd), 64'(v.exp_rd));
    chk({tag, " n_writes"}, 64'(nwr), 64'(v.exp_wr));
    chk({tag, " rsp_cycle"}, 64'(rc), 64'(mrc));
    chk({tag, " bus_cycles"}, 64'(bm), 64'(mbm));
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 21'd0;
    cmd_wdata = 32'd0; cmd_mask = 32'd0; cmd_limit = 16'd0; rsp_ready = 1'b1;
    cur_seq = '0; rd_idx = 3'd0;

    tbl[0] = mk_vec(2'd0, 21'h000C0, 32'hA5, 32'h0, 16'd0,
                    mk_seq(32'h11, 32'h22, 32'h33, 32'h44), 32'h0, 1'b0, 0, 1);
    tbl[1] = mk_vec(2'd1, 21'h00100, 32'h0, 32'h0, 16'd0,
                    mk_seq(32'h12345678, 32'h0, 32'h0, 32'h0), 32'h12345678, 1'b0, 1, 0);
    tbl[2] = mk_vec(2'd2, 21'h00200, 32'h1, 32'h1, 16'd5,
                    mk_seq(32'h0, 32'h0, 32'h1, 32'h1), 32'h1, 1'b0, 3, 0);
    tbl[3] = mk_vec(2'd2, 21'h00204, 32'h55, 32'hFF, 16'd4,
                    mk_seq(32'h0, 32'h1, 32'h2, 32'h3), 32'h3, 1'b1, 4, 0);
    tbl[4] = mk_vec(2'd2, 21'h00208, 32'h55, 32'hFF, 16'd0,
                    mk_seq(32'h7, 32'h8, 32'h9, 32'hA), 32'h7, 1'b1, 1, 0);
    tbl[5] = mk_vec(2'd3, 21'h0030C, 32'hFFFF, 32'hFF, 16'd3,
                    mk_seq(32'h5, 32'h5, 32'h5, 32'h5), 32'h0, 1'b1, 0, 0);
    tbl[6] = mk_vec(2'd2, 21'h00310, 32'h1234, 32'h0, 16'd6,
                    mk_seq(32'hCAFEF00D, 32'h1, 32'h2, 32'h3), 32'hCAFEF00D, 1'b0, 1, 0);
    tbl[7] = mk_vec(2'd2, 21'h1FFFFC, 32'h9, 32'hF, 16'd3,
                    mk_seq(32'h0, 32'h0, 32'hF9, 32'h0), 32'hF9, 1'b0, 3, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_data", 64'(rsp_data), 64'd0);
    chk("rst rsp_err", 64'(rsp_err), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst strobes", 64'({mmio_cs, mmio_wr, mmio_rd}), 64'd0);
    chk("rst addr", 64'(mmio_addr), 64'd0);
    chk("rst wr_data", 64'(mmio_wr_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i], 0, $sformatf("tbl%0d", i));

    run_txn(tbl[1], 10, "backpressure_read");
    run_txn(tbl[5], 10, "backpressure_rsv");

    // Reset during the gap between two poll reads
    @(negedge clk);
    cmd_op = 2'd2; cmd_addr = 21'h00040; cmd_wdata = 32'h1; cmd_mask = 32'h1;
    cmd_limit = 16'd8; cur_seq = '0; rd_idx = 3'd0; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("midpoll first_bus", 64'({mmio_cs, mmio_rd}), 64'h3);
    @(negedge clk);
    chk("midpoll gap_cs", 64'(mmio_cs), 64'd0);
    chk("midpoll gap_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midpoll rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("midpoll rst_strobes", 64'({mmio_cs, mmio_wr, mmio_rd}), 64'd0);
    chk("midpoll rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midpoll rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midpoll after cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midpoll after rsp_valid", 64'(rsp_valid), 64'd0);
    run_txn(tbl[1], 0, "after_midpoll_read");

    // Reset landing on a bus cycle drops the strobes in that same cycle
    @(negedge clk);
    cmd_op = 2'd2; cmd_addr = 21'h00044; cmd_wdata = 32'h1; cmd_mask = 32'h1;
    cmd_limit = 16'd8; cur_seq = '0; rd_idx = 3'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("busrst before_cs", 64'(mmio_cs), 64'd1);
    reset = 1'b1;
    #1;
    chk("busrst strobes", 64'({mmio_cs, mmio_wr, mmio_rd}), 64'd0);
    chk("busrst rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("busrst after cmd_ready", 64'(cmd_ready), 64'd1);
    run_txn(tbl[0], 0, "after_busrst_write");

    for (int n = 0; n < 60; n++) begin
      logic [31:0] md;
      logic        me;
      int          mrd, mwr, mrc, mbm, hold;
      rv.op    = 2'($urandom_range(0, 3));
      rv.addr  = 21'($urandom);
      rv.wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       rv.mask = 32'd0;
        1:       rv.mask = 32'hFFFFFFFF;
        default: rv.mask = $urandom;
      endcase
      rv.limit = 16'($urandom_range(0, 8));
      for (int i = 0; i < 8; i++)
        rv.seq[i] = ($urandom_range(0, 3) == 0) ?
                    ((rv.wdata & rv.mask) | ($urandom & ~rv.mask)) : $urandom;
      model(rv, md, me, mrd, mwr, mrc, mbm);
      rv.exp_data = md; rv.exp_err = me; rv.exp_rd = mrd; rv.exp_wr = mwr;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_txn(rv, hold, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
